// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
//  Module   : iter_alu
//  Purpose  : Sequential EX-stage ALU with valid/ready handshakes. Single-cycle
//             logic/arith/shift/compare ops plus iterative radix-2 MUL/MULHU/
//             DIVU/REMU. Optional build macro ITER_ALU_BYPASS_EN lets a new op
//             be accepted in the same cycle the previous result is consumed.
//  Revision : 1.0  initial release
// ============================================================================
module iter_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0] c_cnt_init = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] c_cnt_one  = (SHW+1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [SHW:0]         r_cnt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_opnd;
   logic                 r_div;
   logic                 r_hi;
   logic [WIDTH-1:0]     r_out;

   logic                 w_accept;
   logic                 w_iter;
   logic                 w_done_ready;
   logic [SHW-1:0]       w_sh;
   logic [WIDTH-1:0]     w_alu;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_shift;
   logic                 w_ge;
   logic [WIDTH-1:0]     w_diff;
   logic [2*WIDTH-1:0]   w_step;
   logic [WIDTH-1:0]     w_res;

`ifdef ITER_ALU_BYPASS_EN
   assign w_done_ready = out_ready;
`else
   assign w_done_ready = 1'b0;
`endif

   assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && w_done_ready);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == BUSY);
   assign out       = r_out;

   assign w_accept = in_valid && in_ready;
   assign w_iter   = (op >= 4'd10) && (op <= 4'd13);
   assign w_sh     = b[SHW-1:0];

   always_comb begin
      w_alu = '0;
      case (op)
         4'd0:    w_alu = a & b;
         4'd1:    w_alu = a | b;
         4'd2:    w_alu = a + b;
         4'd3:    w_alu = a ^ b;
         4'd4:    w_alu = a << w_sh;
         4'd5:    w_alu = a >> w_sh;
         4'd6:    w_alu = a - b;
         4'd7:    w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
         4'd8:    w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         4'd9:    w_alu = $signed(a) >>> w_sh;
         default: w_alu = '0;
      endcase
   end

   // Multiply keeps the multiplier in the low half and shifts right; divide
   // keeps {remainder, quotient} and shifts left. A zero divisor naturally
   // yields an all-ones quotient and a remainder equal to the dividend.
   always_comb begin
      w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
      w_shift = r_acc[2*WIDTH-1:WIDTH-1];
      w_ge    = (w_shift >= {1'b0, r_opnd});
      w_diff  = w_shift[WIDTH-1:0] - r_opnd;
      w_step  = {w_sum, r_acc[WIDTH-1:1]};
      if (r_div) begin
         if (w_ge) begin
            w_step = {w_diff, r_acc[WIDTH-2:0], 1'b1};
         end else begin
            w_step = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
         end
      end
      w_res = r_hi ? w_step[2*WIDTH-1:WIDTH] : w_step[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next_state = w_iter ? BUSY : DONE;
            end
         end
         BUSY: begin
            if (r_cnt == c_cnt_one) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               if (w_accept) begin
                  w_next_state = w_iter ? BUSY : DONE;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_acc  <= '0;
         r_opnd <= '0;
         r_div  <= 1'b0;
         r_hi   <= 1'b0;
         r_out  <= '0;
      end else if (w_accept) begin
         if (w_iter) begin
            r_cnt  <= c_cnt_init;
            r_acc  <= {{WIDTH{1'b0}}, a};
            r_opnd <= b;
            r_div  <= op[2];
            r_hi   <= op[0];
         end else begin
            r_out  <= w_alu;
         end
      end else if (r_state == BUSY) begin
         r_acc <= w_step;
         r_cnt <= r_cnt - c_cnt_one;
         if (r_cnt == c_cnt_one) begin
            r_out <= w_res;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_iter_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iter_alu
//  Purpose  : Self-checking bench for iter_alu (directed + randomized ops).
//  Revision : 1.0  initial release
// ============================================================================
module tb_iter_alu;

   localparam int W = 32;
`ifdef ITER_ALU_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    op = '0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out;
   logic          busy;
   bit            rand_rdy = 1'b0;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [W-1:0] val;
      int           due;
      bit           iter;
   } exp_t;
   exp_t q[$];

   iter_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
      logic [63:0]  p;
      logic [4:0]   s;
      logic [W-1:0] r;
      p = 64'(x) * 64'(y);
      s = y[4:0];
      case (o)
         4'd0:    r = x & y;
         4'd1:    r = x | y;
         4'd2:    r = x + y;
         4'd3:    r = x ^ y;
         4'd4:    r = x << s;
         4'd5:    r = x >> s;
         4'd6:    r = x - y;
         4'd7:    r = (x < y) ? 32'd1 : 32'd0;
         4'd8:    r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd9:    r = $signed(x) >>> s;
         4'd10:   r = p[31:0];
         4'd11:   r = p[63:32];
         4'd12:   r = (y == 0) ? 32'hFFFF_FFFF : x / y;
         4'd13:   r = (y == 0) ? x : x % y;
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
   endtask

   // Cycle-accurate reference: per-cycle expectations derived from the
   // queue of accepted operations and their due cycles.
   initial begin
      bit exp_ov, exp_busy, exp_ir;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            q.delete();
            chk1("rst_out_valid", out_valid, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_in_ready", in_ready, 1'b1);
            chkw("rst_out", out, '0);
         end else begin
            exp_ov   = (q.size() > 0) && (cyc >= q[0].due);
            exp_busy = (q.size() > 0) && q[0].iter && (cyc < q[0].due);
            if (q.size() == 0)       exp_ir = 1'b1;
            else if (cyc < q[0].due) exp_ir = 1'b0;
            else                     exp_ir = BYP && out_ready;
            chk1("out_valid", out_valid, exp_ov);
            chk1("busy", busy, exp_busy);
            chk1("in_ready", in_ready, exp_ir);
            if (exp_ov) chkw("out", out, q[0].val);
            if (exp_ov && out_ready) void'(q.pop_front());
            if (in_valid && exp_ir) begin
               bit it;
               it = (op >= 4'd10) && (op <= 4'd13);
               q.push_back('{val: model(op, a, b), due: cyc + (it ? W + 1 : 1), iter: it});
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int n);
      bit ok;
      in_valid = 1'b1;
      op = o;
      a  = x;
      b  = y;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 200) begin
         @(negedge clk);
         n++;
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) timeout("issue");
   endtask

   task automatic wait_res(output logic [W-1:0] v, output int n, output int nb);
      bit got;
      got = 1'b0;
      v   = '0;
      n   = 0;
      nb  = 0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         if (busy) nb++;
         if (out_valid) begin
            got = 1'b1;
            v   = out;
         end
      end
      if (!got) timeout("wait_res");
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string nm, input logic [3:0] o, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [W-1:0] ev, input int elat,
                      output int nb);
      int n, l;
      logic [W-1:0] v;
      issue(o, x, y, n);
      in_valid = 1'b0;
      wait_res(v, l, nb);
      chkw(nm, v, ev);
      chki({nm, "_lat"}, l, elat);
   endtask

   initial begin
      int n, nb, l;
      logic [W-1:0] v;
      logic [3:0]   ro;
      logic [W-1:0] rx, ry;

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run("add",   4'd2,  32'd10,          32'd7,     32'd17,          1,     nb);
      run("slt",   4'd7,  32'hFFFF_FFFF,   32'd1,     32'd0,           1,     nb);
      run("slts",  4'd8,  32'hFFFF_FFFF,   32'd1,     32'd1,           1,     nb);
      run("sra",   4'd9,  32'h8000_0000,   32'h21,    32'hC000_0000,   1,     nb);
      run("shl",   4'd4,  32'd1,           32'h24,    32'h10,          1,     nb);
      run("sub",   4'd6,  32'd0,           32'd1,     32'hFFFF_FFFF,   1,     nb);
      run("rsvd",  4'd14, 32'h1234,        32'h5678,  32'd0,           1,     nb);
      run("mul",   4'd10, 32'h1234_5678,   32'h100,   32'h3456_7800,   W + 1, nb);
      chki("mul_busy_cycles", nb, W);
      run("mulhu", 4'd11, 32'h1234_5678,   32'h100,   32'h0000_0012,   W + 1, nb);
      run("divu",  4'd12, 32'd100,         32'd7,     32'd14,          W + 1, nb);
      run("remu",  4'd13, 32'd100,         32'd7,     32'd2,           W + 1, nb);
      run("divu0", 4'd12, 32'd5,           32'd0,     32'hFFFF_FFFF,   W + 1, nb);
      run("remu0", 4'd13, 32'd5,           32'd0,     32'd5,           W + 1, nb);

      // Output stall with a competing op offered that must be ignored
      out_ready = 1'b0;
      issue(4'd2, 32'd1, 32'd2, n);
      in_valid = 1'b0;
      wait_res(v, l, nb);
      chkw("stall_first", v, 32'd3);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         op = 4'd2;
         a  = 32'd100;
         b  = 32'd200;
         @(negedge clk);
         chk1("stall_in_ready", in_ready, 1'b0);
         chk1("stall_out_valid", out_valid, 1'b1);
         chkw("stall_out", out, 32'd3);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chkw("stall_release", out, 32'd3);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk1("stall_no_ghost", out_valid, 1'b0);
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a divide
      issue(4'd12, 32'd1000, 32'd3, n);
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk1("mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("arst_out_valid", out_valid, 1'b0);
      chk1("arst_busy", busy, 1'b0);
      chk1("arst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run("add_after_rst", 4'd2, 32'd3, 32'd4, 32'd7, 1, nb);

      // Back-to-back single-cycle ops
      for (int i = 0; i < 4; i++) begin
         issue(4'd2, 32'(i * 10), 32'(i + 1), n);
         if (i > 0) chki("b2b_issue_gap", n, BYP ? 1 : 2);
      end
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Randomized traffic with random output back-pressure
      rand_rdy = 1'b1;
      for (int k = 0; k < 300; k++) begin
         ro = 4'($urandom_range(0, 15));
         rx = $urandom;
         case ($urandom_range(0, 3))
            0:       ry = '0;
            1:       ry = 32'($urandom_range(0, 40));
            default: ry = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) rx = 32'h8000_0000 | 32'($urandom_range(0, 15));
         issue(ro, rx, ry, n);
         if ($urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
         end
      end
      in_valid = 1'b0;
      l = 0;
      while (q.size() != 0 && l < 200) begin
         @(posedge clk);
         #1;
         l++;
      end
      if (q.size() != 0) timeout("drain");
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
